// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seq_mult_pkg;

  // Operand and product widths are fixed for the MULT-class datapath.
  localparam int MULT_W    = 32;
  localparam int PROD_W    = 64;

  // Iteration counter runs 0..ITER_LAST, one add/shift step per cycle.
  localparam int ITER_LAST = 31;
  localparam int CNT_W     = 5;

  // Add/sub unit operation select.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Radix-2 Booth step: whether to touch the accumulator, and in which direction.
  typedef struct packed {
    logic en;
    logic sel;
  } booth_op_t;

  // Decode the Booth pair {lo[0], q}: 01 adds the multiplicand, 10 subtracts it,
  // 00 and 11 are pure shifts.
  function automatic booth_op_t booth_decode(input logic lo0, input logic q);
    booth_op_t op;
    op.en  = 1'b0;
    op.sel = ALU_ADD;
    case ({lo0, q})
      2'b01: begin
        op.en  = 1'b1;
        op.sel = ALU_ADD;
      end
      2'b10: begin
        op.en  = 1'b1;
        op.sel = ALU_SUB;
      end
      default: begin
        op.en  = 1'b0;
        op.sel = ALU_ADD;
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_adder.sv
// 32-bit combinational add/sub unit: sum = a + (sel ? ~b : b) + c_in.
// Latency: combinational, settles within one cycle.
// Backpressure: none, pure function of its inputs.
module adder
  import seq_mult_pkg::*;
(
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  input  logic              c_in,
  input  logic              sel,
  output logic [MULT_W-1:0] sum,
  output logic              c_out,
  output logic              ovf
);

  logic [MULT_W-1:0] b_eff;
  logic [MULT_W:0]   full;

  // Subtraction inverts b; the caller supplies the +1 through c_in.
  // ovf compares the sign of the result against the operand signs actually added.
  always_comb begin
    b_eff = b ^ {MULT_W{sel}};
    full  = {1'b0, a} + {1'b0, b_eff} + {{MULT_W{1'b0}}, c_in};
    sum   = full[MULT_W-1:0];
    c_out = full[MULT_W];
    ovf   = (a[MULT_W-1] == b_eff[MULT_W-1]) && (full[MULT_W-1] != a[MULT_W-1]);
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential 32x32 -> 64 multiplier: one add/sub step per cycle over 32 iterations.
// Latency: done pulses 32 edges after the edge that accepts start; one result per 33 cycles.
// Backpressure: none; start is only looked at in IDLE/DONE, ignored (not queued) while busy.
// Build macro SEQ_MULT_SIGNED_EN selects signed radix-2 Booth; default is unsigned shift-add.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MULT_W-1:0] multiplicand,
  input  logic [MULT_W-1:0] multiplier,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_LAST);

  // Architectural state.
  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [MULT_W-1:0] mcand_q;
  logic [MULT_W-1:0] hi_q;
  logic [MULT_W-1:0] lo_q;
  logic              q_q;
  logic [PROD_W-1:0] product_q;
  logic              done_q;

  // Result of the current iteration (add/sub then right shift).
  logic [MULT_W-1:0] hi_d;
  logic [MULT_W-1:0] lo_d;
  logic              q_d;

  // Add/sub unit hookup.
  logic [MULT_W-1:0] add_sum;
  logic              add_cout;
  logic              add_ovf;
  logic              add_sel;
  logic              add_cin;

  // Accumulator after the optional add, and the bit shifted into hi[31].
  logic [MULT_W-1:0] acc;
  logic              shift_in;

`ifdef SEQ_MULT_SIGNED_EN
  booth_op_t         booth_op;
`endif

  adder u_adder (
    .a     (hi_q),
    .b     (mcand_q),
    .c_in  (add_cin),
    .sel   (add_sel),
    .sum   (add_sum),
    .c_out (add_cout),
    .ovf   (add_ovf)
  );

  // Only one of carry/overflow matters per build, and q is only read by Booth.
  logic unused_flags;
  assign unused_flags = add_cout ^ add_ovf ^ q_q;

`ifdef SEQ_MULT_SIGNED_EN
  // Booth step: optional +/- mcand, then arithmetic shift of {s,hi,lo,q}.
  // s is the true sign of the 33-bit sum so mcand = -2^31 does not wrap.
  always_comb begin
    booth_op = booth_decode(lo_q[0], q_q);
    add_sel  = booth_op.sel;
    add_cin  = booth_op.sel;
    if (booth_op.en) begin
      acc      = add_sum;
      shift_in = add_sum[MULT_W-1] ^ add_ovf;
    end else begin
      acc      = hi_q;
      shift_in = hi_q[MULT_W-1];
    end
    hi_d = {shift_in, acc[MULT_W-1:1]};
    lo_d = {acc[0], lo_q[MULT_W-1:1]};
    q_d  = lo_q[0];
  end
`else
  // Shift-add step: add mcand when lo[0] is set, then logical shift of {c,hi,lo}
  // so the adder carry lands in hi[31].
  always_comb begin
    add_sel = ALU_ADD;
    add_cin = 1'b0;
    if (lo_q[0]) begin
      acc      = add_sum;
      shift_in = add_cout;
    end else begin
      acc      = hi_q;
      shift_in = 1'b0;
    end
    hi_d = {shift_in, acc[MULT_W-1:1]};
    lo_d = {acc[0], lo_q[MULT_W-1:1]};
    q_d  = 1'b0;
  end
`endif

  // Controller FSM: accept start in IDLE/DONE, iterate in CALC, register result and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      q_q       <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q <= multiplicand;
            lo_q    <= multiplier;
            hi_q    <= '0;
            q_q     <= 1'b0;
            count_q <= '0;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          q_q     <= q_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_LAST) begin
            product_q <= {hi_d, lo_d};
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = done_q;
  assign product = product_q;

endmodule
